// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: merges the ALU result stream with a queued
// memory result stream, ALU first, with a starvation-forced drain.
module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int AW           = 5,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  input  logic [AW-1:0]             alu_rd,
  input  logic [XLEN-1:0]           alu_data,
  output logic                      alu_stall,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [AW-1:0]             mem_rd,
  input  logic [XLEN-1:0]           mem_data,
  output logic                      we,
  output logic [AW-1:0]             a3,
  output logic [XLEN-1:0]           wd3,
  output logic [$clog2(LQ_DEPTH):0] lq_count
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW:0]   FULL = LQ_DEPTH[PW:0];
  localparam logic [SW-1:0] LIM  = STARVE_LIMIT[SW-1:0];

  logic [AW-1:0]   r_rd   [LQ_DEPTH];
  logic [XLEN-1:0] r_data [LQ_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_count;
  logic [SW-1:0]   r_starve;

  logic            w_empty;
  logic            w_full;
  logic            w_force;
  logic            w_pop;
  logic            w_alu;
  logic            w_byp;
  logic            w_push;
  logic            w_sel;
  logic            w_wr;
  logic [AW-1:0]   w_rd;
  logic [XLEN-1:0] w_wd;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL);
  assign mem_ready = !w_full;
  assign lq_count  = r_count;

  // Forced drain wins over everything once the queue has waited long enough.
  assign w_force   = (r_starve == LIM) && !w_empty;
  assign w_pop     = !w_empty && (w_force || !alu_valid);
  assign w_alu     = alu_valid && !w_force;
  assign w_byp     = !alu_valid && w_empty && mem_valid;
  assign w_push    = mem_valid && !w_full && !w_byp;
  assign alu_stall = w_force;

  always_comb begin
    w_sel = 1'b0;
    w_rd  = '0;
    w_wd  = '0;
    unique case (1'b1)
      w_pop: begin
        w_sel = 1'b1;
        w_rd  = r_rd[r_rptr];
        w_wd  = r_data[r_rptr];
      end
      w_alu: begin
        w_sel = 1'b1;
        w_rd  = alu_rd;
        w_wd  = alu_data;
      end
      w_byp: begin
        w_sel = 1'b1;
        w_rd  = mem_rd;
        w_wd  = mem_data;
      end
      default: ;
    endcase
  end

  // x0 still consumes its slot but never reaches the regfile.
  assign w_wr = w_sel && (w_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we  <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else begin
      we  <= w_wr;
      a3  <= w_wr ? w_rd : '0;
      wd3 <= w_wr ? w_wd : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= mem_rd;
      r_data[r_wptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_pop || w_empty) begin
      r_starve <= '0;
    end else if (w_alu && (r_starve != LIM)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: per-stream expected-write queues
// filled on accepted handshakes, drained when the regfile port writes.
module tb_wb_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int LQD  = 4;
  localparam int SL   = 3;
  localparam int EW   = AW + XLEN;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  alu_valid = 1'b0;
  logic [AW-1:0]         alu_rd = '0;
  logic [XLEN-1:0]       alu_data = '0;
  logic                  alu_stall;
  logic                  mem_valid = 1'b0;
  logic                  mem_ready;
  logic [AW-1:0]         mem_rd = '0;
  logic [XLEN-1:0]       mem_data = '0;
  logic                  we;
  logic [AW-1:0]         a3;
  logic [XLEN-1:0]       wd3;
  logic [$clog2(LQD):0]  lq_count;

  int n_chk = 0;
  int n_fail = 0;
  logic [EW-1:0] aq[$];
  logic [EW-1:0] mq[$];

  wb_arbiter #(
    .XLEN(XLEN), .AW(AW), .LQ_DEPTH(LQD), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_data(mem_data),
    .we(we), .a3(a3), .wd3(wd3), .lq_count(lq_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor first, then record this cycle's accepted inputs.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst_n) begin
      aq.delete();
      mq.delete();
    end else begin
      if (we) begin
        if (mq.size() != 0 && {a3, wd3} == mq[0]) begin
          e = mq.pop_front();
          check("wb_mem", 64'({a3, wd3}), 64'(e));
        end else if (aq.size() != 0) begin
          e = aq.pop_front();
          check("wb_alu", 64'({a3, wd3}), 64'(e));
        end else begin
          check("wb_unexpected", 64'(we), 64'(0));
        end
      end
      if (alu_valid && !alu_stall && alu_rd != '0)
        aq.push_back({alu_rd, alu_data});
      if (mem_valid && mem_ready && mem_rd != '0)
        mq.push_back({mem_rd, mem_data});
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int ai;
    int mi;
    int k;
    logic a_acc;
    logic m_acc;

    #1;
    check("rst_we", 64'(we), 64'(0));
    check("rst_cnt", 64'(lq_count), 64'(0));
    check("rst_rdy", 64'(mem_ready), 64'(1));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-stream with three queued memory results
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1;
      alu_rd    = (i == 2) ? 5'd3 : 5'd0;
      alu_data  = 32'h3333;
      mem_valid = 1'b1;
      mem_rd    = 5'(11 + i);
      mem_data  = 32'hD000 + 32'(i);
      tick();
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    #1;
    check("t1_cnt_pre", 64'(lq_count), 64'(3));
    check("t1_we_pre", 64'(we), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("t1_we_rst", 64'(we), 64'(0));
    check("t1_a3_rst", 64'(a3), 64'(0));
    check("t1_cnt_rst", 64'(lq_count), 64'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("t1_rdy", 64'(mem_ready), 64'(1));
    check("t1_we_idle", 64'(we), 64'(0));

    // ALU only, including x0
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'h1234;
    #1 check("t2_stall", 64'(alu_stall), 64'(0));
    tick();
    check("t2_we", 64'(we), 64'(1));
    check("t2_a3", 64'(a3), 64'(5));
    check("t2_wd3", 64'(wd3), 64'h1234);
    alu_rd   = 5'd0;
    alu_data = 32'hFFFF;
    tick();
    check("t2_x0_we", 64'(we), 64'(0));
    check("t2_x0_a3", 64'(a3), 64'(0));
    check("t2_x0_wd3", 64'(wd3), 64'(0));
    alu_valid = 1'b0;
    tick();
    check("t2_idle_we", 64'(we), 64'(0));

    // Bypass
    mem_valid = 1'b1;
    mem_rd    = 5'd7;
    mem_data  = 32'hCAFE;
    #1 check("t3_rdy", 64'(mem_ready), 64'(1));
    tick();
    mem_valid = 1'b0;
    check("t3_we", 64'(we), 64'(1));
    check("t3_a3", 64'(a3), 64'(7));
    check("t3_wd3", 64'(wd3), 64'hCAFE);
    check("t3_cnt", 64'(lq_count), 64'(0));
    tick();

    // Starvation: one queued entry, ALU held busy
    k = 0;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(20 + k);
      alu_data  = 32'hA000_0000 + 32'(k);
      mem_valid = (i == 0);
      mem_rd    = 5'd9;
      mem_data  = 32'h9999;
      #1 check("t4_stall", 64'(alu_stall), 64'(i == 4));
      tick();
      if (i == 4) begin
        check("t4_drain_we", 64'(we), 64'(1));
        check("t4_drain_a3", 64'(a3), 64'(9));
        check("t4_drain_wd", 64'(wd3), 64'h9999);
      end else begin
        k++;
      end
      if (i == 5) begin
        check("t4_held_a3", 64'(a3), 64'(24));
        check("t4_held_wd", 64'(wd3), 64'hA000_0004);
      end
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    tick();
    check("t4_cnt", 64'(lq_count), 64'(0));

    // Full queue, forced drains and pointer wrap
    ai = 0;
    mi = 0;
    for (int c = 0; c < 40; c++) begin
      alu_valid = (c < 24);
      alu_rd    = AW'(16 + ai % 15);
      alu_data  = 32'hA500_0000 + 32'(ai);
      mem_valid = (mi < 6);
      mem_rd    = AW'(1 + mi);
      mem_data  = 32'hB000_0000 + 32'(mi);
      #1;
      if (c == 4) begin
        check("t5_full_cnt", 64'(lq_count), 64'(4));
        check("t5_full_rdy", 64'(mem_ready), 64'(0));
        check("t5_full_stall", 64'(alu_stall), 64'(1));
      end
      if (c == 5) begin
        check("t5_freed_cnt", 64'(lq_count), 64'(3));
        check("t5_freed_rdy", 64'(mem_ready), 64'(1));
      end
      if (c == 6) check("t5_refull_rdy", 64'(mem_ready), 64'(0));
      @(negedge clk);
      a_acc = alu_valid && !alu_stall;
      m_acc = mem_valid && mem_ready;
      tick();
      if (a_acc) ai++;
      if (m_acc) mi++;
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    check("t5_pushes", 64'(mi), 64'(6));
    check("t5_cnt_end", 64'(lq_count), 64'(0));
    repeat (3) tick();
    check("sb_alu_empty", 64'(aq.size()), 64'(0));
    check("sb_mem_empty", 64'(mq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writer side of the integer register file: merges the single-cycle ALU result stream and the variable-latency memory/load result stream onto the one regfile write port (we, a3, wd3).
- ALU results have priority; memory results are buffered in a small FIFO.
- A starvation counter forces a memory drain by stalling the ALU.
- Sits between the execute/memory stages and the regfile write port in the pipeline.

Parameters:
XLEN, 32, data width of results and wd3
AW, 5, register address width
LQ_DEPTH, 4, memory-result FIFO depth (power of two, >=2)
STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO may be bypassed before the ALU is stalled

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
alu_valid  input  1  ALU result present this cycle
alu_rd  input  AW  ALU destination register
alu_data  input  XLEN  ALU result
alu_stall  output  1  ALU result not accepted this cycle; upstream holds it
mem_valid  input  1  memory result offered
mem_ready  output  1  FIFO can accept memory result
mem_rd  input  AW  memory destination register
mem_data  input  XLEN  memory result
we  output  1  regfile write enable (registered)
a3  output  AW  regfile write address (registered)
wd3  output  XLEN  regfile write data (registered)
lq_count  output  clog2(LQ_DEPTH)+1  FIFO occupancy

Behaviour:
Interface:
- One clock, clk.
- Reset is asynchronous, active-low, rst_n.

Reset:
- Asserting rst_n low at any time immediately clears we=0, a3=0, wd3=0, the FIFO pointers, lq_count=0 and the starve counter.
- In-flight entries are discarded.

mem handshake:
- Transfer occurs when mem_valid && mem_ready.
- mem_ready = (lq_count != LQ_DEPTH). It is based on registered occupancy only; a same-cycle pop does not free space.
- Upstream holds mem_rd/mem_data stable while mem_valid && !mem_ready.

Selection, evaluated each cycle (combinational select, registered output):
- S1, forced drain: starve == STARVE_LIMIT and FIFO non-empty. Pop the FIFO head and write it. alu_stall=1. The ALU result is not consumed.
- S2, ALU: alu_valid and not S1. Write the ALU result. alu_stall=0. If the FIFO is non-empty, starve increments.
- S3, FIFO: !alu_valid and FIFO non-empty. Pop the head and write it.
- S4, bypass: !alu_valid, FIFO empty, mem_valid. The memory result is written directly, is not pushed, and mem_ready stays 1.
- Otherwise: no write, we=0 next cycle.
- Outside S1, alu_stall=0.

Starve counter:
- Increments only in S2 with a non-empty FIFO.
- Clears on any FIFO pop (S1/S3) or when the FIFO becomes empty.
- Saturates at STARVE_LIMIT.

Push:
- In S1/S2/S3, an accepted memory transfer is pushed.
- In S1/S3 with a full FIFO, the push is refused because mem_ready=0.
- Push and pop in the same cycle leave lq_count unchanged.

Latency:
- A selected result appears on we/a3/wd3 on the next rising clk edge and lasts exactly one cycle.
- The ALU path has 1 cycle of latency.
- A memory result is written 1 cycle after acceptance at best (bypass), 2+ cycles if queued.

x0:
- A selected result with rd==0 still consumes its slot (pop/accept).
- It drives we=0; a3 and wd3 are don't-care, driven as 0.

Ordering:
- Memory results are written in acceptance order.
- No ordering is enforced between the ALU and memory streams; hazard logic upstream owns WAW.

Wrap-around:
- FIFO pointers wrap modulo LQ_DEPTH.
- lq_count is the full/empty source of truth.

Test Plan:
1. Reset mid-stream: 3 mem entries queued, rst_n low between clock edges -> we=0 and lq_count=0 at once; after release, mem_ready=1.
2. ALU only: alu_valid with rd=5, data=0x1234 -> next cycle we=1, a3=5, wd3=0x1234, alu_stall=0; rd=0 -> we=0.
3. Bypass: FIFO empty, alu idle, mem rd=7, data=0xCAFE -> next cycle we=1, a3=7, wd3=0xCAFE; lq_count stays 0.
4. Starvation: alu_valid held high, one mem entry rd=9 queued -> 3 ALU writes, then alu_stall=1 for one cycle with a3=9 written, then the held ALU result is written.
5. Full FIFO: alu_valid continuous, LQ_DEPTH=4 mem pushes -> lq_count=4, mem_ready=0; each forced drain frees a slot; pops return entries in push order, including pointer wrap after 6 total pushes.
